// File: rtl/mac_tx_arbiter_if.sv
// Interface bundling the frame-source and MAC TX signals of mac_tx_arbiter.
// Ports (all in the mac_tx_clk domain):
//   src_req   [N_SRC]    source i holds a complete frame
//   src_data  [8*N_SRC]  FWFT byte of source i at [8*i +: 8]
//   src_last  [N_SRC]    current byte of source i is its final byte
//   src_rd    [N_SRC]    pop strobe, at most one bit set
//   src_gnt   [N_SRC]    one-hot owner of the MAC
//   mac_tx_*             sof/eof/valid/data towards the MAC
//   frm_done, frm_trunc  eof-cycle status pulses
// Modport master is the arbiter side; slave is the sources/MAC side.
interface mac_tx_arbiter_if #(
  parameter int unsigned N_SRC = 4
) ();
  logic [N_SRC-1:0]   src_req;
  logic [8*N_SRC-1:0] src_data;
  logic [N_SRC-1:0]   src_last;
  logic [N_SRC-1:0]   src_rd;
  logic [N_SRC-1:0]   src_gnt;
  logic               mac_tx_sof;
  logic               mac_tx_eof;
  logic               mac_tx_valid;
  logic [7:0]         mac_tx_data;
  logic               frm_done;
  logic               frm_trunc;

  modport master (
    input  src_req, src_data, src_last,
    output src_rd, src_gnt, mac_tx_sof, mac_tx_eof, mac_tx_valid, mac_tx_data,
           frm_done, frm_trunc
  );

  modport slave (
    output src_req, src_data, src_last,
    input  src_rd, src_gnt, mac_tx_sof, mac_tx_eof, mac_tx_valid, mac_tx_data,
           frm_done, frm_trunc
  );
endinterface

// File: rtl/mac_tx_arbiter.sv
// Round-robin scheduler sharing one MAC TX byte stream among N_SRC FWFT frame sources.
// Short frames are zero-padded to MIN_LEN, long frames are truncated at MAX_LEN and the
// rest of the source frame is drained; at least GAP_CYCLES separate an eof from the next sof.
// Ports:
//   i_mac_tx_clk  TX byte clock, only clock
//   i_rst_n       asynchronous active-low reset
//   io_bus        mac_tx_arbiter_if.master: source handshake in, MAC stream and status out
module mac_tx_arbiter #(
  parameter int unsigned N_SRC      = 4,
  parameter int unsigned MIN_LEN    = 60,
  parameter int unsigned MAX_LEN    = 1514,
  parameter int unsigned GAP_CYCLES = 26
) (
  input  logic             i_mac_tx_clk,
  input  logic             i_rst_n,
  mac_tx_arbiter_if.master io_bus
);
  localparam int unsigned IdxW = $clog2(N_SRC);
  localparam int unsigned CntW = $clog2(MAX_LEN + 1);
  localparam int unsigned GapW = (GAP_CYCLES > 4) ? $clog2(GAP_CYCLES) : 2;
  // The counter is loaded in the cycle before the eof output and IDLE must be reached
  // two cycles before the earliest sof, hence the offset of 3.
  localparam logic [GapW-1:0] GapLoad = GapW'(GAP_CYCLES - 3);

  typedef enum logic [2:0] {StIdle, StSend, StPad, StDrain, StGap} state_e;

  state_e            r_state, w_state_d;
  logic [IdxW-1:0]   r_ptr, w_ptr_d;        // RR pointer, doubles as current owner
  logic [CntW-1:0]   r_byte_cnt, w_cnt_d;
  logic [GapW-1:0]   r_gap_cnt, w_gap_d;
  logic              r_sof, w_sof_d;
  logic              r_eof, w_eof_d;
  logic              r_valid, w_valid_d;
  logic [7:0]        r_data, w_data_d;
  logic              r_trunc, w_trunc_d;

  logic              w_found;
  logic [IdxW-1:0]   w_win;
  logic [IdxW-1:0]   w_cand;
  logic [7:0]        w_cur_data;
  logic              w_cur_last;
  logic [CntW-1:0]   w_cnt_inc;
  logic              w_own;
  logic [N_SRC-1:0]  w_gnt;

  // First requester searching upward from pointer+1, wrapping modulo N_SRC.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_cand  = '0;
    for (int unsigned k = 1; k <= N_SRC; k++) begin
      w_cand = IdxW'((32'(r_ptr) + k) % N_SRC);
      if (!w_found && io_bus.src_req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  always_comb begin
    w_cur_data = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (r_ptr == IdxW'(i)) w_cur_data = io_bus.src_data[8*i +: 8];
    end
  end

  assign w_cur_last = io_bus.src_last[r_ptr];
  assign w_cnt_inc  = r_byte_cnt + 1'b1;

  always_comb begin
    w_state_d = r_state;
    w_ptr_d   = r_ptr;
    w_cnt_d   = r_byte_cnt;
    w_gap_d   = (r_gap_cnt != '0) ? r_gap_cnt - 1'b1 : '0;
    w_sof_d   = 1'b0;
    w_eof_d   = 1'b0;
    w_valid_d = 1'b0;
    w_data_d  = '0;
    w_trunc_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_state_d = StSend;
          w_ptr_d   = w_win;
          w_cnt_d   = '0;
        end
      end
      StSend: begin
        w_valid_d = 1'b1;
        w_data_d  = w_cur_data;
        w_sof_d   = (r_byte_cnt == '0);
        w_cnt_d   = w_cnt_inc;
        if (w_cur_last) begin
          if (w_cnt_inc >= CntW'(MIN_LEN)) begin
            w_eof_d   = 1'b1;
            w_gap_d   = GapLoad;
            w_state_d = StGap;
          end else begin
            w_state_d = StPad;
          end
        end else if (w_cnt_inc == CntW'(MAX_LEN)) begin
          w_eof_d   = 1'b1;
          w_trunc_d = 1'b1;
          w_gap_d   = GapLoad;
          w_state_d = StDrain;
        end
      end
      StPad: begin
        w_valid_d = 1'b1;
        w_cnt_d   = w_cnt_inc;
        if (w_cnt_inc == CntW'(MIN_LEN)) begin
          w_eof_d   = 1'b1;
          w_gap_d   = GapLoad;
          w_state_d = StGap;
        end
      end
      StDrain: begin
        // Gap counter keeps running here so drain time counts toward the gap.
        if (w_cur_last) w_state_d = StGap;
      end
      StGap: begin
        if (r_gap_cnt == '0) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_mac_tx_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_ptr      <= IdxW'(N_SRC - 1);
      r_byte_cnt <= '0;
      r_gap_cnt  <= '0;
      r_sof      <= 1'b0;
      r_eof      <= 1'b0;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_trunc    <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_ptr      <= w_ptr_d;
      r_byte_cnt <= w_cnt_d;
      r_gap_cnt  <= w_gap_d;
      r_sof      <= w_sof_d;
      r_eof      <= w_eof_d;
      r_valid    <= w_valid_d;
      r_data     <= w_data_d;
      r_trunc    <= w_trunc_d;
    end
  end

  // The owner is popped in SEND and DRAIN; PAD no longer touches the source.
  assign w_own = (r_state == StSend) || (r_state == StDrain);
  assign w_gnt = w_own ? (N_SRC'(1) << r_ptr) : '0;

  assign io_bus.src_gnt      = w_gnt;
  assign io_bus.src_rd       = w_gnt;
  assign io_bus.mac_tx_sof   = r_sof;
  assign io_bus.mac_tx_eof   = r_eof;
  assign io_bus.mac_tx_valid = r_valid;
  assign io_bus.mac_tx_data  = r_data;
  assign io_bus.frm_done     = r_eof;
  assign io_bus.frm_trunc    = r_trunc;
endmodule
